// File: rtl/fx_inv_cdf_zs.sv
// -----------------------------------------------------------------------------
// fx_inv_cdf_zs
//   Final stage of the Gaussian inverse-CDF lane. Converts the tail variable
//   t = sqrt(-2 ln x), x in (0,0.5], into a signed z-score using the Zelen &
//   Severo rational approximation
//       z = t - (c0 + c1 t + c2 t^2) / (1 + d1 t + d2 t^2 + d3 t^3)
//   optionally negated. Five register stages, one sample per cycle, elastic
//   valid/ready. All arithmetic is signed Q(QINT).(QFRAC) and saturating.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   valid_in   in   t/negate valid
//   ready_out  out  stage accepts a sample this cycle
//   t          in   signed tail variable (negative values clamp to 0)
//   negate     in   1 = output -z
//   valid_out  out  z valid
//   ready_in   in   downstream accepts z
//   z          out  signed z-score
//
// Optional build macro: FXINVCDF_ZS_ASSERT_EN adds concurrent assertions
// (stall hold, denominator floor, X-check on z). Datapath is unaffected.
// -----------------------------------------------------------------------------
module fx_inv_cdf_zs #(
    parameter int WIDTH = 32,
    parameter int QINT  = 16,
    parameter int QFRAC = WIDTH - QINT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [WIDTH-1:0] t,
    input  logic                    negate,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [WIDTH-1:0] z
);

    if (QINT + QFRAC != WIDTH) begin : g_bad_format
        $error("fx_inv_cdf_zs: QINT + QFRAC must equal WIDTH");
    end

    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [2*WIDTH-1:0] dword_t;

    localparam dword_t WMAX = dword_t'({1'b0, {(WIDTH-1){1'b1}}});
    localparam dword_t WMIN = -WMAX - dword_t'(1);

    localparam word_t ONE = word_t'(1) <<< QFRAC;
    localparam word_t C0  = word_t'($rtoi(2.515517 * (2.0 ** QFRAC) + 0.5));
    localparam word_t C1  = word_t'($rtoi(0.802853 * (2.0 ** QFRAC) + 0.5));
    localparam word_t C2  = word_t'($rtoi(0.010328 * (2.0 ** QFRAC) + 0.5));
    localparam word_t D1  = word_t'($rtoi(1.432788 * (2.0 ** QFRAC) + 0.5));
    localparam word_t D2  = word_t'($rtoi(0.189269 * (2.0 ** QFRAC) + 0.5));
    localparam word_t D3  = word_t'($rtoi(0.001308 * (2.0 ** QFRAC) + 0.5));

    // ---------------------------------------------------------------- helpers
    function automatic word_t sat_w(input dword_t v);
        if (v > WMAX)      return word_t'(WMAX);
        else if (v < WMIN) return word_t'(WMIN);
        else               return word_t'(v);
    endfunction

    // Rounded fixed-point multiply: full product, +half LSB, >>> QFRAC.
    function automatic word_t fmul(input word_t a, input word_t b);
        dword_t p;
        p = dword_t'(a) * dword_t'(b);
        p = p + (dword_t'(1) <<< (QFRAC - 1));
        return sat_w(p >>> QFRAC);
    endfunction

    function automatic word_t sadd(input word_t a, input word_t b);
        return sat_w(dword_t'(a) + dword_t'(b));
    endfunction

    function automatic word_t ssub(input word_t a, input word_t b);
        return sat_w(dword_t'(a) - dword_t'(b));
    endfunction

    // -(min) saturates to max.
    function automatic word_t sneg(input word_t a);
        return sat_w(-dword_t'(a));
    endfunction

    // ---------------------------------------------------------------- state
    logic  [5:1] vld_q, vld_d;
    logic  [5:1] neg_q, neg_d;

    word_t s1_t_q,   s1_t_d;
    word_t s1_t2_q,  s1_t2_d;
    word_t s2_t_q,   s2_t_d;
    word_t s2_num_q, s2_num_d;
    word_t s2_dp_q,  s2_dp_d;
    word_t s2_t3_q,  s2_t3_d;
    word_t s3_t_q,   s3_t_d;
    word_t s3_num_q, s3_num_d;
    word_t s3_den_q, s3_den_d;
    word_t s4_t_q,   s4_t_d;
    word_t s4_q_q,   s4_q_d;
    word_t z_q,      z_d;

    dword_t divisor;
    word_t  zr;
    logic   ce;

    // Whole pipeline freezes only when the output register holds an
    // unaccepted sample; bubbles keep flowing otherwise.
    assign ce        = !vld_q[5] || ready_in;
    assign ready_out = ce;
    assign valid_out = vld_q[5];
    assign z         = z_q;

    always_comb begin
        vld_d    = {vld_q[4:1], valid_in};
        neg_d    = {neg_q[4:1], negate};

        // S1: clamp and square
        s1_t_d   = t[WIDTH-1] ? '0 : t;
        s1_t2_d  = fmul(s1_t_d, s1_t_d);

        // S2: cube, numerator, partial denominator
        s2_t_d   = s1_t_q;
        s2_t3_d  = fmul(s1_t2_q, s1_t_q);
        s2_num_d = sadd(sadd(C0, fmul(C1, s1_t_q)), fmul(C2, s1_t2_q));
        s2_dp_d  = sadd(sadd(ONE, fmul(D1, s1_t_q)), fmul(D2, s1_t2_q));

        // S3: finish denominator
        s3_t_d   = s2_t_q;
        s3_num_d = s2_num_q;
        s3_den_d = sadd(s2_dp_q, fmul(D3, s2_t3_q));

        // S4: quotient. Valid samples always have den >= ONE; the floor only
        // matters for the all-zero bubble registers right after reset.
        divisor  = (s3_den_q < ONE) ? dword_t'(ONE) : dword_t'(s3_den_q);
        s4_t_d   = s3_t_q;
        s4_q_d   = sat_w((dword_t'(s3_num_q) <<< QFRAC) / divisor);

        // S5: subtract and apply sign
        zr       = ssub(s4_t_q, s4_q_q);
        z_d      = neg_q[4] ? sneg(zr) : zr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            neg_q    <= '0;
            s1_t_q   <= '0;
            s1_t2_q  <= '0;
            s2_t_q   <= '0;
            s2_num_q <= '0;
            s2_dp_q  <= '0;
            s2_t3_q  <= '0;
            s3_t_q   <= '0;
            s3_num_q <= '0;
            s3_den_q <= '0;
            s4_t_q   <= '0;
            s4_q_q   <= '0;
            z_q      <= '0;
        end else if (ce) begin
            vld_q    <= vld_d;
            neg_q    <= neg_d;
            s1_t_q   <= s1_t_d;
            s1_t2_q  <= s1_t2_d;
            s2_t_q   <= s2_t_d;
            s2_num_q <= s2_num_d;
            s2_dp_q  <= s2_dp_d;
            s2_t3_q  <= s2_t3_d;
            s3_t_q   <= s3_t_d;
            s3_num_q <= s3_num_d;
            s3_den_q <= s3_den_d;
            s4_t_q   <= s4_t_d;
            s4_q_q   <= s4_q_d;
            z_q      <= z_d;
        end
    end

`ifdef FXINVCDF_ZS_ASSERT_EN
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        valid_out && !ready_in |=> $stable(z) && valid_out)
        else $error("InvCDF_ZS: stall overwrite");

    a_den_floor: assert property (@(posedge clk) disable iff (rst)
        vld_q[3] |-> (s3_den_q >= ONE))
        else $error("InvCDF_ZS: denominator below ONE");

    a_z_known: assert property (@(posedge clk) disable iff (rst)
        valid_out |-> !$isunknown(z))
        else $error("InvCDF_ZS: X on z");
`endif

endmodule

// File: tb/tb_fx_inv_cdf_zs.sv
// -----------------------------------------------------------------------------
// tb_fx_inv_cdf_zs
//   Self-checking bench for fx_inv_cdf_zs. A scoreboard queue receives the
//   reference z of every accepted sample; the monitor compares each output
//   transfer against it bit-exactly. Directed points are also checked against
//   the true inverse-CDF values with a tolerance.
// -----------------------------------------------------------------------------
module tb_fx_inv_cdf_zs;

    localparam int WIDTH = 32;
    localparam int QINT  = 16;
    localparam int QFRAC = 16;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
    localparam longint ONE  = 64'sd65536;
    localparam longint C0   = 64'sd164857;
    localparam longint C1   = 64'sd52616;
    localparam longint C2   = 64'sd677;
    localparam longint D1   = 64'sd93899;
    localparam longint D2   = 64'sd12404;
    localparam longint D3   = 64'sd86;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_in;
    logic                    ready_out;
    logic signed [WIDTH-1:0] t;
    logic                    negate;
    logic                    valid_out;
    logic                    ready_in;
    logic signed [WIDTH-1:0] z;

    int checks = 0;
    int errors = 0;

    longint expq[$];
    int     out_cyc[$];
    int     outs = 0;
    int     cyc  = 0;
    longint e_val;
    logic   prev_stall = 1'b0;
    longint prev_z;

    always #5 clk = ~clk;

    fx_inv_cdf_zs #(
        .WIDTH (WIDTH),
        .QINT  (QINT),
        .QFRAC (QFRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .t         (t),
        .negate    (negate),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .z         (z)
    );

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol = 0);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic longint sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint fm(input longint a, input longint b);
        return sat((a * b + 64'sd32768) >>> QFRAC);
    endfunction

    function automatic longint ref_z(input longint tin, input logic neg);
        longint tt, t2, t3, num, den, q, zr;
        tt  = (tin < 0) ? 0 : tin;
        t2  = fm(tt, tt);
        t3  = fm(t2, tt);
        num = sat(sat(C0 + fm(C1, tt)) + fm(C2, t2));
        den = sat(sat(sat(ONE + fm(D1, tt)) + fm(D2, t2)) + fm(D3, t3));
        q   = sat((num * ONE) / den);
        zr  = sat(tt - q);
        return neg ? sat(-zr) : zr;
    endfunction

    function automatic logic signed [WIDTH-1:0] rand_t();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 6 * 65536);
            1:       return $urandom_range(76800, 393216);
            2:       return $urandom();
            default: return $urandom_range(0, 65536);
        endcase
    endfunction

    // ------------------------------------------------------ monitor
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", valid_out, 1);
                check("stall_hold_z", z, prev_z);
            end
            prev_stall = valid_out && !ready_in;
            prev_z     = z;
            if (valid_out && ready_in) begin
                outs++;
                out_cyc.push_back(cyc);
                check("out_has_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e_val = expq.pop_front();
                    check("z_model", z, e_val);
                end
            end
            if (valid_in && ready_out) expq.push_back(ref_z(t, negate));
        end
    end

    // ------------------------------------------------------ driver helpers
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic signed [WIDTH-1:0] tv, input logic nv);
        int n;
        valid_in = 1'b1;
        t        = tv;
        negate   = nv;
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", n, 0);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic get_out(output longint zv, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_out && lat < 50);
        if (!valid_out) check("out_timeout", lat, 0);
        zv = z;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        longint zv;
        int     lat;
        int     o0;

        rst      = 1'b1;
        valid_in = 1'b0;
        t        = '0;
        negate   = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_z", z, 0);
        check("rst_ready_out", ready_out, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed points against true z-scores
        send(32'sh00012D6A, 1'b0);
        get_out(zv, lat);
        check("latency_first", lat, 5);
        check("z_t1p177", zv, 0, 33);
        @(posedge clk); #1;

        send(32'sd178011, 1'b0);
        get_out(zv, lat);
        check("z_t2p716_pos", zv, 128451, 66);
        @(posedge clk); #1;

        send(32'sd178011, 1'b1);
        get_out(zv, lat);
        check("z_t2p716_neg", zv, -128451, 66);
        @(posedge clk); #1;

        send(32'sd238243, 1'b1);
        get_out(zv, lat);
        check("z_t3p635_neg", zv, -196608, 66);
        @(posedge clk); #1;

        send(-32'sd65536, 1'b0);
        get_out(zv, lat);
        check("z_tneg_clamp", zv, -164857, 66);
        @(posedge clk); #1;

        // Back-to-back
        out_cyc.delete();
        for (int i = 0; i < 20; i++) send(rand_t(), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 50 && out_cyc.size() < 20; n++) @(negedge clk);
        check("b2b_count", out_cyc.size(), 20);
        if (out_cyc.size() >= 20) check("b2b_span", out_cyc[19] - out_cyc[0], 19);
        wait_drain("b2b_drain");

        // Stall with samples in flight
        o0 = outs;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_t(), 1'($urandom_range(0, 1)));
        get_out(zv, lat);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        t        = rand_t();
        negate   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", valid_out, 1);
            check("stall_z", z, zv);
            check("stall_ready_out", ready_out, 0);
        end
        @(posedge clk);
        #1 ready_in = 1'b1;
        @(negedge clk);
        check("release_ready_out", ready_out, 1);
        @(posedge clk);
        #1 valid_in = 1'b0;
        wait_drain("stall_drain");
        check("stall_out_count", outs - o0, 4);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) send(rand_t(), 1'($urandom_range(0, 1)));
        o0  = outs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_valid", valid_out, 0);
        end
        check("midrst_z", z, 0);
        check("midrst_ready", ready_out, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_stale", valid_out, 0);
        end
        check("postrst_out_count", outs, o0);
        @(posedge clk);
        #1;
        send(32'sd178011, 1'b0);
        get_out(zv, lat);
        check("postrst_latency", lat, 5);
        check("postrst_z", zv, 128451, 66);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            t        = rand_t();
            negate   = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        wait_drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fx_inv_cdf_zs.md
Name:
fx_inv_cdf_zs

Overview:
- Final stage of the Gaussian inverse-CDF lane. It converts the tail variable t = sqrt(-2·ln x), with x in (0,0.5], into a signed z-score.
- Uses the Zelen & Severo rational approximation: z = t − (c0 + c1·t + c2·t²)/(1 + d1·t + d2·t² + d3·t³).
- A sign flag carried from the front end selects negation.
- Fully pipelined (one sample per cycle), elastic valid/ready, signed fixed point. Sits after the sqrt unit and feeds the path generator.

Parameters:
- WIDTH, 32, total signed fixed-point word width.
- QINT, 16, integer bits including sign.
- QFRAC, WIDTH-QINT (16), fractional bits. Must satisfy QINT+QFRAC == WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  t/negate valid.
- ready_out  out  1  stage can accept a sample this cycle.
- t  in  WIDTH  signed Q(QINT).(QFRAC) tail variable.
- negate  in  1  1 = output −z.
- valid_out  out  1  z valid.
- ready_in  in  1  downstream accepts z.
- z  out  WIDTH  signed Q(QINT).(QFRAC) z-score.

Behaviour:
- Coefficients are localparams: round(c·2^QFRAC) of c0=2.515517, c1=0.802853, c2=0.010328, d1=1.432788, d2=0.189269, d3=0.001308, and ONE = 1<<QFRAC.
- Fixed multiply: full 2·WIDTH signed product, add 1<<(QFRAC−1), arithmetic shift right by QFRAC, saturate to the WIDTH signed range. Adds and subtracts also saturate.
- Negative t is clamped to 0 at capture.
- Pipeline: 5 register stages, latency 5 cycles with no stall. Each stage carries a valid bit and the negate flag.
  - S1: capture t and negate; t2 = t·t.
  - S2: t3 = t2·t; num = c0 + c1·t + c2·t2; dpart = ONE + d1·t + d2·t2.
  - S3: den = dpart + d3·t3; forward num and t.
  - S4: q = (num << QFRAC) / den, as a signed 2·WIDTH-by-WIDTH integer divide, saturated. den ≥ ONE, so the divisor is never zero.
  - S5: zr = t − q; z = negate ? −zr : zr. Saturate, with −(min) mapping to max.
- Handshake:
  - ce = !valid_out || ready_in; ready_out = ce.
  - All stages advance only when ce = 1. A sample is accepted on valid_in && ready_out.
  - Bubbles propagate as valid = 0. No internal bubble squeezing is required.
- Stall: while valid_out && !ready_in, z, valid_out and every stage register hold their value exactly, and ready_out = 0. No sample is lost or duplicated.
- Throughput: 1 sample/cycle when ready_in is held high.
- Reset:
  - All valid bits, negate flags and data registers go to 0, so valid_out = 0, z = 0, and ready_out = 1 immediately.
  - Reset asserted mid-stream discards all in-flight samples.
- Accuracy: |z − Φ⁻¹| ≤ 4.5e-4 from the approximation plus ≤ 8 LSB of quantisation, for t in [1.17, 6.0].
- Simultaneous accept and output transfer in the same cycle is allowed; both occur.

Optional Feature:
- Macro FXINVCDF_ZS_ASSERT_EN.
- When defined, the module contains concurrent assertions, disabled during rst:
  - valid_out && !ready_in |=> $stable(z) && valid_out, error message "InvCDF_ZS: stall overwrite".
  - den is never less than ONE.
  - X-check on z whenever valid_out = 1.
- When undefined, no assertion code is present. RTL behaviour is identical either way.

Test Plan:
- After reset: valid_out=0, z=0, ready_out=1. Drive t=1.17741 (0x00012D6A), negate=0, ready_in=1 → after 5 cycles valid_out=1 and z = 0.0 ±0.0005 (|z| ≤ 33 LSB).
- t=2.71620 (x=0.025): negate=0 → z = 1.95996 ±0.001 (≈0x0001F5C3); negate=1 → z = −1.95996 ±0.001.
- t=3.63530 (x=0.00135), negate=1 → z = −3.000 ±0.001. Also t=−1.0 → treated as t=0, giving z = −2.5155 ±0.001.
- Back-to-back: 20 consecutive samples with ready_in=1 → 20 outputs on 20 consecutive cycles, in order, each matching the reference model.
- Stall: with samples in flight, hold ready_in=0 for 10 cycles → valid_out and z stable and ready_out=0 throughout. On release, all samples drain in order with none dropped.
- Reset mid-stream: assert rst with 3 samples in flight → valid_out=0 during reset and afterwards, no stale outputs. The next input yields a correct result after 5 cycles.
